// File: rtl/seg_display_scheduler_pkg.sv
// seg_pkg: segment map, sizes and scan-state type shared by the display scheduler
package seg_pkg;
    localparam int DIGITS = 4;
    localparam int PRESC_W = 26;
    localparam int TAP_W = $clog2(PRESC_W);
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [0:15][6:0] SEG_MAP = {
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
    typedef enum logic {BLANK, SHOW} scan_state_e;
endpackage

// File: rtl/seg_display_scheduler_hex_decoder.sv
// seg_hex_decoder: hex nibble to active-low 7-segment pattern
module seg_hex_decoder
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] segments
);
    assign segments = SEG_MAP[nibble];
endmodule

// File: rtl/seg_display_scheduler.sv
// seg_display_scheduler: blanked 4-digit scan with frame-aligned base/overlay arbitration
module seg_display_scheduler
    import seg_pkg::*;
#(
    parameter int TAP0 = 15,
    parameter int TAP1 = 19,
    parameter int TAP2 = 25,
    parameter int BLANK_CYCLES = 4,
    parameter int HOLD_FRAMES = 8
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        speed_sel,
    input  logic [15:0]       src0_value,
    input  logic              src1_req,
    input  logic [15:0]       src1_value,
    output logic              src1_ack,
    output logic              active_src,
    output logic              frame_done,
    output logic [DIGITS-1:0] grounds,
    output logic [6:0]        segmentBits
);
    localparam int BW = $clog2(BLANK_CYCLES) + 1;
    localparam int HW = $clog2(HOLD_FRAMES + 1);
    localparam int DW = $clog2(DIGITS);

    function automatic logic [TAP_W-1:0] tap_of(input logic [1:0] s);
        return s == 2'd0 ? TAP_W'(TAP0) : s == 2'd1 ? TAP_W'(TAP1) : TAP_W'(TAP2);
    endfunction

    logic [PRESC_W-1:0] cnt;
    logic               tap_prev, tap_prev_n, pending, pending_n, active_n;
    logic               tick, boundary, service;
    logic [1:0]         spd, spd_n;
    scan_state_e        state, state_n;
    logic [BW-1:0]      bc, bc_n;
    logic [DW-1:0]      digit, digit_n;
    logic [HW-1:0]      hold, hold_n;
    logic [15:0]        base, base_n, ovl, ovl_n, shown;
    logic [3:0]         nib;
    logic [6:0]         dec;

    seg_hex_decoder u_dec (.nibble(nib), .segments(dec));

    always_comb begin
        tick = cnt[tap_of(spd)] & ~tap_prev;
        boundary = state == BLANK && bc == BW'(BLANK_CYCLES - 1) && digit == '0;
        service = boundary && pending;
        state_n = state == BLANK ? (bc == BW'(BLANK_CYCLES - 1) ? SHOW : BLANK) : (tick ? BLANK : SHOW);
        bc_n = state == BLANK && state_n == BLANK ? bc + BW'(1) : '0;
        digit_n = state == SHOW && tick ? digit + DW'(1) : digit;
        spd_n = boundary ? speed_sel : spd;
        // tracking the tap actually in use next cycle keeps a rate change from faking an edge
        tap_prev_n = cnt[tap_of(spd_n)];
        pending_n = boundary ? src1_req : pending | src1_req;
        base_n = boundary ? src0_value : base;
        ovl_n = service ? src1_value : ovl;
        hold_n = service ? HW'(HOLD_FRAMES) : boundary && active_src ? hold - HW'(1) : hold;
        active_n = service || (active_src && (!boundary || hold_n != '0));
        shown = active_n ? ovl_n : base_n;
        nib = shown[{digit_n, 2'b00} +: 4];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt         <= '0;
            tap_prev    <= 1'b0;
            spd         <= '0;
            state       <= BLANK;
            bc          <= '0;
            digit       <= '0;
            pending     <= 1'b0;
            hold        <= '0;
            base        <= '0;
            ovl         <= '0;
            active_src  <= 1'b0;
            src1_ack    <= 1'b0;
            frame_done  <= 1'b0;
            grounds     <= '0;
            segmentBits <= SEG_BLANK;
        end else begin
            cnt         <= cnt + PRESC_W'(1);
            tap_prev    <= tap_prev_n;
            spd         <= spd_n;
            state       <= state_n;
            bc          <= bc_n;
            digit       <= digit_n;
            pending     <= pending_n;
            hold        <= hold_n;
            base        <= base_n;
            ovl         <= ovl_n;
            active_src  <= active_n;
            src1_ack    <= service;
            frame_done  <= boundary;
            grounds     <= state_n == SHOW ? DIGITS'(1) << digit_n : '0;
            segmentBits <= state_n == SHOW ? dec : SEG_BLANK;
        end
    end
endmodule
